// File: rtl/gd_vblank_sync.sv
// gd_vblank_sync
//   Frame-synchronous double buffer for game data. Snapshots from the game
//   core land in a pending register and move to the committed output only
//   at the start of vertical sync. The drawing stage therefore never sees a
//   half-updated field. Also keeps a frame counter and a blink bit.
//
// Ports
//   clk_i        pixel clock
//   rst_i        synchronous, active-high reset
//   gd_i         snapshot from the game core
//   gd_valid_i   gd_i valid
//   gd_ready_o   block can accept a snapshot (combinational)
//   vga_vs_i     vertical sync as driven to the monitor
//   gd_o         committed snapshot, stable for a whole frame
//   gd_update_o  one-cycle pulse in the cycle gd_o takes a new value
//   frame_cnt_o  count of vsync starts, wraps
//   blink_o      frame_cnt_o[BLINK_BIT]
//   drop_cnt_o   saturating count of overwritten pending snapshots
module gd_vblank_sync #(
  parameter int unsigned GD_WIDTH        = 1024,
  parameter int unsigned OVERWRITE       = 0,
  parameter int unsigned FRAME_CNT_WIDTH = 8,
  parameter int unsigned BLINK_BIT       = 5,
  parameter logic        VS_POLARITY     = 1'b0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [GD_WIDTH-1:0]        gd_i,
  input  logic                       gd_valid_i,
  output logic                       gd_ready_o,
  input  logic                       vga_vs_i,
  output logic [GD_WIDTH-1:0]        gd_o,
  output logic                       gd_update_o,
  output logic [FRAME_CNT_WIDTH-1:0] frame_cnt_o,
  output logic                       blink_o,
  output logic [7:0]                 drop_cnt_o
);

  localparam logic OVW = (OVERWRITE != 0);

  logic [GD_WIDTH-1:0] pend;
  logic                pend_valid;
  logic                vs_d;
  logic                acc;
  logic                vs_start;
  logic                commit;

  // Ready depends only on reset and the pending flag, never on gd_valid_i.
  assign gd_ready_o = !rst_i && (OVW || !pend_valid);
  assign acc        = gd_valid_i && gd_ready_o;
  assign vs_start   = (vga_vs_i == VS_POLARITY) && (vs_d != VS_POLARITY);
  assign commit     = vs_start && pend_valid;
  assign blink_o    = frame_cnt_o[BLINK_BIT];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // vs_d resets to the active level so a vsync already in progress at
      // reset release does not look like a fresh vsync start.
      vs_d        <= VS_POLARITY;
      pend_valid  <= 1'b0;
      gd_o        <= '0;
      gd_update_o <= 1'b0;
      frame_cnt_o <= '0;
      drop_cnt_o  <= '0;
    end else begin
      vs_d        <= vga_vs_i;
      gd_update_o <= commit;

      if (vs_start)
        frame_cnt_o <= frame_cnt_o + FRAME_CNT_WIDTH'(1);

      if (commit)
        gd_o <= pend;

      // A simultaneous accept wins: old pend is committed above, new data
      // becomes pending, and the flag stays set.
      if (acc)
        pend_valid <= 1'b1;
      else if (commit)
        pend_valid <= 1'b0;

      // Only an overwrite that destroys an uncommitted snapshot is a drop.
      if (OVW && acc && pend_valid && !commit && drop_cnt_o != 8'hFF)
        drop_cnt_o <= drop_cnt_o + 8'd1;
    end
  end

  // Data path register: no reset needed, pend_valid guards its use.
  always_ff @(posedge clk_i) begin
    if (acc)
      pend <= gd_i;
  end

endmodule

// File: tb/tb_gd_vblank_sync.sv
module tb_gd_vblank_sync;
  localparam int W = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  gd_in = '0;
  logic          valid = 1'b0;
  logic          vs = 1'b0;

  logic [W-1:0]  d_gd[2];
  logic          d_upd[2];
  logic [7:0]    d_frame[2];
  logic          d_blink[2];
  logic [7:0]    d_drop[2];
  logic          d_rdy[2];

  always #5 clk = ~clk;

  gd_vblank_sync #(.GD_WIDTH(W), .OVERWRITE(0)) u_stall (
    .clk_i(clk), .rst_i(rst), .gd_i(gd_in), .gd_valid_i(valid),
    .gd_ready_o(d_rdy[0]), .vga_vs_i(vs), .gd_o(d_gd[0]),
    .gd_update_o(d_upd[0]), .frame_cnt_o(d_frame[0]), .blink_o(d_blink[0]),
    .drop_cnt_o(d_drop[0]));

  gd_vblank_sync #(.GD_WIDTH(W), .OVERWRITE(1)) u_ovw (
    .clk_i(clk), .rst_i(rst), .gd_i(gd_in), .gd_valid_i(valid),
    .gd_ready_o(d_rdy[1]), .vga_vs_i(vs), .gd_o(d_gd[1]),
    .gd_update_o(d_upd[1]), .frame_cnt_o(d_frame[1]), .blink_o(d_blink[1]),
    .drop_cnt_o(d_drop[1]));

  int checks = 0;
  int errs   = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: instance 0 stalls, instance 1 overwrites.
  logic [W-1:0] m_gd[2];
  logic [W-1:0] m_pend[2];
  bit           m_pv[2];
  bit           m_upd[2];
  int           m_frame[2];
  int           m_drop[2];
  logic         m_prev_vs;

  always @(posedge clk) begin
    bit start, acc, commit, was;
    start = (vs == 1'b0) && (m_prev_vs != 1'b0);
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_gd[i] = '0; m_upd[i] = 0; m_pv[i] = 0; m_frame[i] = 0; m_drop[i] = 0;
      end else begin
        was    = m_pv[i];
        acc    = valid && (i == 1 || !was);
        commit = start && was;
        m_upd[i] = commit;
        if (start) m_frame[i] = (m_frame[i] + 1) % 256;
        if (commit) m_gd[i] = m_pend[i];
        if (acc) begin
          if (i == 1 && was && !commit && m_drop[i] < 255) m_drop[i]++;
          m_pend[i] = gd_in;
        end
        m_pv[i] = acc ? 1'b1 : (commit ? 1'b0 : was);
      end
    end
    m_prev_vs = rst ? 1'b0 : vs;
  end

  bit chk_en = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("gd_o[%0d]", i), d_gd[i], m_gd[i]);
        chk($sformatf("gd_update_o[%0d]", i), W'(d_upd[i]), W'(m_upd[i]));
        chk($sformatf("frame_cnt_o[%0d]", i), W'(d_frame[i]), W'(m_frame[i]));
        chk($sformatf("blink_o[%0d]", i), W'(d_blink[i]), W'((m_frame[i] >> 5) & 1));
        chk($sformatf("drop_cnt_o[%0d]", i), W'(d_drop[i]), W'(m_drop[i]));
        chk($sformatf("gd_ready_o[%0d]", i), W'(d_rdy[i]), W'(!rst && (i == 1 || !m_pv[i])));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic offer(input logic [W-1:0] d);
    valid = 1'b1; gd_in = d; tick(); valid = 1'b0;
  endtask

  localparam logic [W-1:0] PA5 = 64'hA5A5_A5A5_A5A5_A5A5;
  localparam logic [W-1:0] PA  = 64'h0000_0000_0000_AAAA;
  localparam logic [W-1:0] PB  = 64'h0000_0000_0000_BBBB;
  localparam logic [W-1:0] PC  = 64'h0000_0000_0000_CCCC;
  localparam logic [W-1:0] PD  = 64'h0000_0000_0000_DDDD;

  initial begin
    int   toggles;
    bit   saw_wrap;
    logic pb;
    logic [7:0] pf;

    // Reset with vsync held active.
    rst = 1'b1; vs = 1'b0; valid = 1'b1; gd_in = PA5;
    tick();
    chk_en = 1;
    ticks(2);
    chk("reset gd_o", d_gd[0], '0);
    chk("reset ready", W'(d_rdy[0]), '0);
    chk("reset frame", W'(d_frame[1]), '0);
    rst = 1'b0; valid = 1'b0;
    offer(PA5);
    ticks(4);
    chk("no commit in held vsync", d_gd[0], '0);
    chk("frame held vsync", W'(d_frame[0]), '0);
    vs = 1'b1; ticks(3);
    vs = 1'b0; tick();
    chk("first commit gd_o", d_gd[0], PA5);
    chk("first commit update", W'(d_upd[0]), 1);
    chk("first commit frame", W'(d_frame[0]), 1);

    // Stall mode: A then B offered back-to-back.
    vs = 1'b1; valid = 1'b1; gd_in = PA; tick();
    gd_in = PB;
    chk("A accepted, ready low", W'(d_rdy[0]), '0);
    ticks(3);
    vs = 1'b0; tick();
    chk("vsync1 gd_o=A", d_gd[0], PA);
    chk("ready after commit", W'(d_rdy[0]), 1);
    tick(); valid = 1'b0;
    vs = 1'b1; ticks(3);
    vs = 1'b0; tick();
    chk("vsync2 gd_o=B", d_gd[0], PB);
    chk("stall drops zero", W'(d_drop[0]), '0);

    // One-cycle reset with a snapshot pending.
    vs = 1'b1; offer(PC); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mid reset gd_o", d_gd[0], '0);
    chk("mid reset gd_o ovw", d_gd[1], '0);
    tick();
    vs = 1'b0; tick();
    chk("no update after reset", W'(d_upd[0]), '0);
    chk("frame after reset vsync", W'(d_frame[0]), 1);

    // Overwrite mode: A, B, C in one frame.
    vs = 1'b1; tick();
    offer(PA); tick(); offer(PB); tick(); offer(PC); ticks(2);
    vs = 1'b0; tick();
    chk("ovw commit C", d_gd[1], PC);
    chk("ovw drops 2", W'(d_drop[1]), 2);
    chk("ovw update", W'(d_upd[1]), 1);
    tick();
    chk("ovw single pulse", W'(d_upd[1]), '0);

    // Overwrite mode: D accepted on the vs_start cycle with C pending.
    vs = 1'b1; tick(); offer(PC); ticks(2);
    vs = 1'b0; valid = 1'b1; gd_in = PD; tick(); valid = 1'b0;
    chk("simul commit gd_o=C", d_gd[1], PC);
    chk("simul drops unchanged", W'(d_drop[1]), 2);
    vs = 1'b1; ticks(2);
    vs = 1'b0; tick();
    chk("next vsync gd_o=D", d_gd[1], PD);
    chk("drops still 2", W'(d_drop[1]), 2);

    // 256 vsync pulses, no snapshots.
    toggles = 0; saw_wrap = 0; pb = d_blink[0]; pf = d_frame[0];
    for (int f = 0; f < 256; f++) begin
      vs = 1'b1; ticks(2);
      vs = 1'b0; tick();
      if (d_blink[0] != pb) toggles++;
      if (pf == 8'hFF && d_frame[0] == 8'h00) saw_wrap = 1;
      pb = d_blink[0]; pf = d_frame[0];
      tick();
    end
    chk("blink toggles in 256 frames", W'(toggles), 8);
    chk("frame wrap observed", W'(saw_wrap), 1);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      valid = ($urandom_range(1) == 1);
      gd_in = {$urandom, $urandom};
      if ($urandom_range(5) == 0) vs = ~vs;
      rst = ($urandom_range(149) == 0);
      tick();
    end
    rst = 1'b0; valid = 1'b0;
    ticks(2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
